// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the shared RAM.
// slave  : arbiter side (takes requests and RAM read data, drives stalls, responses, RAM controls)
// master : core + RAM side
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 10
);
  // fetch port
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_flush;
  logic              if_stall;
  logic              if_valid;
  logic [31:0]       if_rdata;
  // data port
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_stall;
  logic              d_valid;
  logic [31:0]       d_rdata;
  // RAM port
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_stall, if_valid, if_rdata, d_stall, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_stall, if_valid, if_rdata, d_stall, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port BRAM (1-cycle read latency) between instruction fetch and data access.
// Ports: clk, rst (sync, active-high), bus (mem_port_arbiter_if.slave).
// One grant per cycle; data has priority unless fetch has waited MAX_DGRANT data grants.
// Responses arrive exactly one cycle after the grant; each port keeps its last read word.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned MAX_DGRANT = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(MAX_DGRANT + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D_RD, OWN_D_WR} owner_t;

  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [31:0]      if_hold_q, d_hold_q;
  logic             if_grant, d_grant;
  logic             if_valid_c, d_valid_c, d_rd_valid_c;
  logic             starved_c;

  // Address bits outside the word index are intentionally ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                              bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

  assign starved_c = (starve_q == CNT_W'(MAX_DGRANT));

  // Arbitration: data first, fetch wins once it has been starved long enough.
  always_comb begin
    if_grant = 1'b0;
    d_grant  = 1'b0;
    if (!rst) begin
      if (bus.if_req && (!bus.d_req || starved_c)) if_grant = 1'b1;
      else if (bus.d_req)                           d_grant  = 1'b1;
    end
  end

  // Next response owner and starvation count.
  always_comb begin
    owner_d  = OWN_NONE;
    starve_d = starve_q;
    if (if_grant)     owner_d = OWN_IF;
    else if (d_grant) owner_d = bus.d_we ? OWN_D_WR : OWN_D_RD;
    if (if_grant || !bus.if_req)  starve_d = '0;
    else if (d_grant && !starved_c) starve_d = starve_q + CNT_W'(1);
  end

  // State and hold registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_NONE;
      starve_q  <= '0;
      if_hold_q <= '0;
      d_hold_q  <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      if (if_valid_c)   if_hold_q <= bus.mem_rdata;
      if (d_rd_valid_c) d_hold_q  <= bus.mem_rdata;
    end
  end

  // Response flags; a flush only ever hides a fetch response.
  assign if_valid_c   = !rst && (owner_q == OWN_IF) && !bus.if_flush;
  assign d_valid_c    = !rst && ((owner_q == OWN_D_RD) || (owner_q == OWN_D_WR));
  assign d_rd_valid_c = !rst && (owner_q == OWN_D_RD);

  assign bus.if_stall = !rst && bus.if_req && !if_grant;
  assign bus.d_stall  = !rst && bus.d_req  && !d_grant;
  assign bus.if_valid = if_valid_c;
  assign bus.d_valid  = d_valid_c;
  assign bus.if_rdata = rst ? 32'h0 : (if_valid_c   ? bus.mem_rdata : if_hold_q);
  assign bus.d_rdata  = rst ? 32'h0 : (d_rd_valid_c ? bus.mem_rdata : d_hold_q);

  // RAM drive for the granted access; idle bus is all zero.
  always_comb begin
    bus.mem_en    = if_grant || d_grant;
    bus.mem_we    = 4'h0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'h0;
    if (if_grant) begin
      bus.mem_addr = bus.if_addr[ADDR_W+1:2];
    end else if (d_grant) begin
      bus.mem_addr = bus.d_addr[ADDR_W+1:2];
      if (bus.d_we) begin
        bus.mem_we    = bus.d_be;
        bus.mem_wdata = bus.d_wdata;
      end
    end
  end
endmodule
